// File: rtl/wave_reg_if_if.sv
// CPU-side register bus of the wave channel: one access per cycle, with registered read data.
interface wave_reg_if_if;
    logic [7:0] addr;
    logic       wrEn;
    logic       rdEn;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdValid;

    modport master (output addr, wrEn, rdEn, wdata, input rdata, rdValid);
    modport slave  (input addr, wrEn, rdEn, wdata, output rdata, rdValid);
endinterface

// File: rtl/wave_reg_if.sv
// Wave channel register file: NR30-NR34 control registers, the 32-sample wave RAM,
// the trigger pulse and the registered CPU read path.
module wave_reg_if (
    input  logic          clk,
    input  logic          rstN,
    input  logic          apuOn,
    wave_reg_if_if.slave  bus,
    output logic          enable,
    output logic [1:0]    vol,
    output logic [7:0]    lenLoad,
    output logic          lenEnable,
    output logic [10:0]   freq,
    output logic          trigger,
    output logic [127:0]  samples
);
    localparam logic [7:0] ADDR_NR30 = 8'h1A;
    localparam logic [7:0] ADDR_NR31 = 8'h1B;
    localparam logic [7:0] ADDR_NR32 = 8'h1C;
    localparam logic [7:0] ADDR_NR33 = 8'h1D;
    localparam logic [7:0] ADDR_NR34 = 8'h1E;

    logic        enable_reg, enable_next;
    logic [1:0]  vol_reg, vol_next;
    logic [7:0]  len_load_reg, len_load_next;
    logic        len_enable_reg, len_enable_next;
    logic [10:0] freq_reg, freq_next;
    logic        trigger_reg, trigger_next;
    logic [7:0]  rdata_reg, rdata_next;
    logic        rd_valid_reg, rd_valid_next;
    logic [3:0]  sample_reg [32];

    logic        wave_hit;
    logic [3:0]  wave_idx;
    logic        wave_wr;
    logic        rd_enable;
    logic [1:0]  rd_vol;
    logic        rd_len_enable;
    logic [7:0]  rd_byte;

    assign wave_hit = (bus.addr[7:4] == 4'h3);
    assign wave_idx = bus.addr[3:0];
    assign wave_wr  = bus.wrEn & wave_hit;

    // Control register updates; power-off clears every cycle and blocks writes.
    always_comb begin
        enable_next     = enable_reg;
        vol_next        = vol_reg;
        len_load_next   = len_load_reg;
        len_enable_next = len_enable_reg;
        freq_next       = freq_reg;
        trigger_next    = 1'b0;
        if (!apuOn) begin
            enable_next     = 1'b0;
            vol_next        = 2'b00;
            len_load_next   = 8'h00;
            len_enable_next = 1'b0;
            freq_next       = 11'h000;
        end else if (bus.wrEn) begin
            case (bus.addr)
                ADDR_NR30: enable_next   = bus.wdata[7];
                ADDR_NR31: len_load_next = bus.wdata;
                ADDR_NR32: vol_next      = bus.wdata[6:5];
                ADDR_NR33: freq_next[7:0] = bus.wdata;
                ADDR_NR34: begin
                    len_enable_next = bus.wdata[6];
                    freq_next[10:8] = bus.wdata[2:0];
                    // An NR34 write never changes enable, so the current DAC state gates the pulse.
                    trigger_next    = bus.wdata[7] & enable_reg;
                end
                default: ;
            endcase
        end
    end

    // Reads see cleared fields while powered off, even before the registers have cleared.
    always_comb begin
        rd_enable     = apuOn & enable_reg;
        rd_vol        = apuOn ? vol_reg : 2'b00;
        rd_len_enable = apuOn & len_enable_reg;
        case (bus.addr)
            ADDR_NR30: rd_byte = {rd_enable, 7'h7F};
            ADDR_NR31: rd_byte = 8'hFF;
            ADDR_NR32: rd_byte = {1'b1, rd_vol, 5'h1F};
            ADDR_NR33: rd_byte = 8'hFF;
            ADDR_NR34: rd_byte = {1'b1, rd_len_enable, 6'h3F};
            default: begin
                if (wave_hit) begin
                    rd_byte = {sample_reg[{wave_idx, 1'b0}], sample_reg[{wave_idx, 1'b1}]};
                end else begin
                    rd_byte = 8'hFF;
                end
            end
        endcase
    end

    always_comb begin
        rd_valid_next = bus.rdEn & ~bus.wrEn;
        rdata_next    = rd_valid_next ? rd_byte : rdata_reg;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            enable_reg     <= 1'b0;
            vol_reg        <= 2'b00;
            len_load_reg   <= 8'h00;
            len_enable_reg <= 1'b0;
            freq_reg       <= 11'h000;
            trigger_reg    <= 1'b0;
            rdata_reg      <= 8'h00;
            rd_valid_reg   <= 1'b0;
        end else begin
            enable_reg     <= enable_next;
            vol_reg        <= vol_next;
            len_load_reg   <= len_load_next;
            len_enable_reg <= len_enable_next;
            freq_reg       <= freq_next;
            trigger_reg    <= trigger_next;
            rdata_reg      <= rdata_next;
            rd_valid_reg   <= rd_valid_next;
        end
    end

    // Each byte of wave RAM holds two samples, the even one in the high nibble.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sample
            always_ff @(posedge clk) begin
                if (!rstN) begin
                    sample_reg[gi] <= 4'h0;
                end else if (wave_wr && (wave_idx == 4'(gi / 2))) begin
                    if ((gi % 2) == 0) begin
                        sample_reg[gi] <= bus.wdata[7:4];
                    end else begin
                        sample_reg[gi] <= bus.wdata[3:0];
                    end
                end
            end
            assign samples[4*gi+3 -: 4] = sample_reg[gi];
        end
    endgenerate

    assign enable      = enable_reg;
    assign vol         = vol_reg;
    assign lenLoad     = len_load_reg;
    assign lenEnable   = len_enable_reg;
    assign freq        = freq_reg;
    assign trigger     = trigger_reg;
    assign bus.rdata   = rdata_reg;
    assign bus.rdValid = rd_valid_reg;
endmodule

// File: tb/tb_wave_reg_if.sv
// Directed table-driven bench for wave_reg_if plus hand sequences for power-off and reset corners.
module tb_wave_reg_if;
    logic         clk = 1'b0;
    logic         rstN;
    logic         apuOn;
    logic         enable;
    logic [1:0]   vol;
    logic [7:0]   lenLoad;
    logic         lenEnable;
    logic [10:0]  freq;
    logic         trigger;
    logic [127:0] samples;

    wave_reg_if_if bus ();

    wave_reg_if dut (
        .clk       (clk),
        .rstN      (rstN),
        .apuOn     (apuOn),
        .bus       (bus),
        .enable    (enable),
        .vol       (vol),
        .lenLoad   (lenLoad),
        .lenEnable (lenEnable),
        .freq      (freq),
        .trigger   (trigger),
        .samples   (samples)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        apu;
        logic [7:0]  addr;
        logic        wr;
        logic        rd;
        logic [7:0]  wd;
        logic [7:0]  e_rdata;
        logic        e_rv;
        logic        e_trig;
        logic        e_en;
        logic [1:0]  e_vol;
        logic [7:0]  e_ll;
        logic        e_le;
        logic [10:0] e_freq;
    } vec_t;

    vec_t vecs [36];
    int total = 0;
    int bad = 0;
    logic [127:0] exp_samples;

    function automatic vec_t v(input logic apu, input logic [7:0] addr, input logic wr, input logic rd,
                               input logic [7:0] wd, input logic [7:0] e_rdata, input logic e_rv,
                               input logic e_trig, input logic e_en, input logic [1:0] e_vol,
                               input logic [7:0] e_ll, input logic e_le, input logic [10:0] e_freq);
        vec_t r;
        r.apu = apu; r.addr = addr; r.wr = wr; r.rd = rd; r.wd = wd;
        r.e_rdata = e_rdata; r.e_rv = e_rv; r.e_trig = e_trig; r.e_en = e_en;
        r.e_vol = e_vol; r.e_ll = e_ll; r.e_le = e_le; r.e_freq = e_freq;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_state(input int idx, input logic [7:0] e_rdata, input logic e_rv, input logic e_trig,
                             input logic e_en, input logic [1:0] e_vol, input logic [7:0] e_ll,
                             input logic e_le, input logic [10:0] e_freq);
        chk("rdata", idx, 128'(bus.rdata), 128'(e_rdata));
        chk("rdValid", idx, 128'(bus.rdValid), 128'(e_rv));
        chk("trigger", idx, 128'(trigger), 128'(e_trig));
        chk("enable", idx, 128'(enable), 128'(e_en));
        chk("vol", idx, 128'(vol), 128'(e_vol));
        chk("lenLoad", idx, 128'(lenLoad), 128'(e_ll));
        chk("lenEnable", idx, 128'(lenEnable), 128'(e_le));
        chk("freq", idx, 128'(freq), 128'(e_freq));
    endtask

    // Drive one access for one clock, then settle just after the edge.
    task automatic cycle(input logic rst_n, input logic apu, input logic [7:0] addr, input logic wr,
                         input logic rd, input logic [7:0] wd);
        rstN      = rst_n;
        apuOn     = apu;
        bus.addr  = addr;
        bus.wrEn  = wr;
        bus.rdEn  = rd;
        bus.wdata = wd;
        @(posedge clk);
        #1;
        $display("txn rstN=%0b apu=%0b addr=%02h wr=%0b rd=%0b wd=%02h -> rdata=%02h rv=%0b trig=%0b",
                 rst_n, apu, addr, wr, rd, wd, bus.rdata, bus.rdValid, trigger);
    endtask

    initial begin
        //          apu  addr   wr rd wd      rdata  rv tr en vol    ll     le freq
        vecs[0]  = v(1, 8'h1A, 1, 0, 8'h80, 8'h00, 0, 0, 1, 2'd0, 8'h00, 0, 11'h000);
        vecs[1]  = v(1, 8'h1E, 1, 0, 8'hC5, 8'h00, 0, 1, 1, 2'd0, 8'h00, 1, 11'h500);
        vecs[2]  = v(1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 2'd0, 8'h00, 1, 11'h500);
        vecs[3]  = v(1, 8'h1D, 1, 0, 8'h34, 8'h00, 0, 0, 1, 2'd0, 8'h00, 1, 11'h534);
        vecs[4]  = v(1, 8'h1E, 0, 1, 8'h00, 8'hFF, 1, 0, 1, 2'd0, 8'h00, 1, 11'h534);
        vecs[5]  = v(1, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 0, 1, 2'd0, 8'h00, 1, 11'h534);
        vecs[6]  = v(1, 8'h1A, 0, 1, 8'h00, 8'hFF, 1, 0, 1, 2'd0, 8'h00, 1, 11'h534);
        vecs[7]  = v(1, 8'h1A, 1, 0, 8'h00, 8'hFF, 0, 0, 0, 2'd0, 8'h00, 1, 11'h534);
        vecs[8]  = v(1, 8'h1E, 1, 0, 8'h80, 8'hFF, 0, 0, 0, 2'd0, 8'h00, 0, 11'h034);
        vecs[9]  = v(1, 8'h1E, 0, 1, 8'h00, 8'hBF, 1, 0, 0, 2'd0, 8'h00, 0, 11'h034);
        vecs[10] = v(1, 8'h1A, 0, 1, 8'h00, 8'h7F, 1, 0, 0, 2'd0, 8'h00, 0, 11'h034);
        vecs[11] = v(1, 8'h30, 1, 0, 8'hA5, 8'h7F, 0, 0, 0, 2'd0, 8'h00, 0, 11'h034);
        vecs[12] = v(1, 8'h3F, 1, 0, 8'h3C, 8'h7F, 0, 0, 0, 2'd0, 8'h00, 0, 11'h034);
        vecs[13] = v(1, 8'h3F, 0, 1, 8'h00, 8'h3C, 1, 0, 0, 2'd0, 8'h00, 0, 11'h034);
        vecs[14] = v(1, 8'h30, 0, 1, 8'h00, 8'hA5, 1, 0, 0, 2'd0, 8'h00, 0, 11'h034);
        vecs[15] = v(1, 8'h1C, 1, 0, 8'hFF, 8'hA5, 0, 0, 0, 2'd3, 8'h00, 0, 11'h034);
        vecs[16] = v(1, 8'h1C, 0, 1, 8'h00, 8'hFF, 1, 0, 0, 2'd3, 8'h00, 0, 11'h034);
        vecs[17] = v(1, 8'h1C, 1, 0, 8'h40, 8'hFF, 0, 0, 0, 2'd2, 8'h00, 0, 11'h034);
        vecs[18] = v(1, 8'h1C, 0, 1, 8'h00, 8'hDF, 1, 0, 0, 2'd2, 8'h00, 0, 11'h034);
        vecs[19] = v(1, 8'h1B, 0, 1, 8'h00, 8'hFF, 1, 0, 0, 2'd2, 8'h00, 0, 11'h034);
        vecs[20] = v(1, 8'h20, 0, 1, 8'h00, 8'hFF, 1, 0, 0, 2'd2, 8'h00, 0, 11'h034);
        vecs[21] = v(1, 8'h1B, 1, 0, 8'h5A, 8'hFF, 0, 0, 0, 2'd2, 8'h5A, 0, 11'h034);
        vecs[22] = v(1, 8'h20, 1, 0, 8'h12, 8'hFF, 0, 0, 0, 2'd2, 8'h5A, 0, 11'h034);
        vecs[23] = v(1, 8'h3F, 0, 1, 8'h00, 8'h3C, 1, 0, 0, 2'd2, 8'h5A, 0, 11'h034);
        vecs[24] = v(1, 8'h1B, 1, 1, 8'h77, 8'h3C, 0, 0, 0, 2'd2, 8'h77, 0, 11'h034);
        vecs[25] = v(1, 8'h1A, 1, 0, 8'h80, 8'h3C, 0, 0, 1, 2'd2, 8'h77, 0, 11'h034);
        vecs[26] = v(1, 8'h1E, 1, 0, 8'hC0, 8'h3C, 0, 1, 1, 2'd2, 8'h77, 1, 11'h034);
        vecs[27] = v(1, 8'h1E, 1, 0, 8'h87, 8'h3C, 0, 1, 1, 2'd2, 8'h77, 0, 11'h734);
        vecs[28] = v(1, 8'h00, 0, 0, 8'h00, 8'h3C, 0, 0, 1, 2'd2, 8'h77, 0, 11'h734);
        vecs[29] = v(0, 8'h00, 0, 0, 8'h00, 8'h3C, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        vecs[30] = v(0, 8'h1C, 1, 0, 8'h20, 8'h3C, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        vecs[31] = v(0, 8'h1A, 0, 1, 8'h00, 8'h7F, 1, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        vecs[32] = v(0, 8'h1C, 0, 1, 8'h00, 8'h9F, 1, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        vecs[33] = v(0, 8'h31, 1, 0, 8'hE1, 8'h9F, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        vecs[34] = v(0, 8'h31, 0, 1, 8'h00, 8'hE1, 1, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        vecs[35] = v(0, 8'h30, 0, 1, 8'h00, 8'hA5, 1, 0, 0, 2'd0, 8'h00, 0, 11'h000);

        // Reset state
        cycle(0, 1, 8'h00, 0, 0, 8'h00);
        cycle(0, 1, 8'h00, 0, 0, 8'h00);
        chk_state(100, 8'h00, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        chk("samples", 100, samples, 128'h0);

        for (int i = 0; i < 36; i++) begin
            cycle(1, vecs[i].apu, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wd);
            chk_state(i, vecs[i].e_rdata, vecs[i].e_rv, vecs[i].e_trig, vecs[i].e_en,
                      vecs[i].e_vol, vecs[i].e_ll, vecs[i].e_le, vecs[i].e_freq);
        end

        // Wave RAM image: 0x30=A5, 0x31=E1 (written while powered off), 0x3F=3C
        exp_samples          = '0;
        exp_samples[3:0]     = 4'hA;
        exp_samples[7:4]     = 4'h5;
        exp_samples[11:8]    = 4'hE;
        exp_samples[15:12]   = 4'h1;
        exp_samples[123:120] = 4'h3;
        exp_samples[127:124] = 4'hC;
        chk("samples", 200, samples, exp_samples);

        // Power drops while a trigger pulse is on the output
        cycle(1, 1, 8'h1A, 1, 0, 8'h80);
        chk_state(300, 8'hA5, 0, 0, 1, 2'd0, 8'h00, 0, 11'h000);
        cycle(1, 1, 8'h1E, 1, 0, 8'h80);
        chk_state(301, 8'hA5, 0, 1, 1, 2'd0, 8'h00, 0, 11'h000);
        cycle(1, 0, 8'h1E, 1, 0, 8'h80);
        chk_state(302, 8'hA5, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        cycle(1, 0, 8'h00, 0, 0, 8'h00);
        chk_state(303, 8'hA5, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        chk("samples", 304, samples, exp_samples);

        // Reset overrides a simultaneous trigger write and read
        cycle(1, 1, 8'h1A, 1, 0, 8'h80);
        chk_state(400, 8'hA5, 0, 0, 1, 2'd0, 8'h00, 0, 11'h000);
        cycle(1, 1, 8'h3F, 0, 1, 8'h00);
        chk_state(401, 8'h3C, 1, 0, 1, 2'd0, 8'h00, 0, 11'h000);
        cycle(0, 1, 8'h1E, 1, 1, 8'h80);
        chk_state(402, 8'h00, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        chk("samples", 402, samples, 128'h0);
        cycle(1, 1, 8'h00, 0, 0, 8'h00);
        chk_state(403, 8'h00, 0, 0, 0, 2'd0, 8'h00, 0, 11'h000);
        chk("samples", 403, samples, 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wave_reg_if.md
WAVE_REG_IF -- requirements
Module: wave_reg_if

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports named clk and rstN.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rstN  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 apuOn  input  1  master sound power (NR52 bit 7); 0 = sound off.
REQ-005 addr  input  8  low byte of CPU address FFxx.
REQ-006 wrEn  input  1  write strobe, one access per cycle high.
REQ-007 rdEn  input  1  read strobe, one access per cycle high.
REQ-008 wdata  input  8  write data.
REQ-009 rdata  output  8  registered read data.
REQ-010 rdValid  output  1  high for exactly the one cycle that carries rdata for a read.
REQ-011 enable  output  1  DAC power, NR30 bit 7.
REQ-012 vol  output  2  volume code, NR32 bits 6:5.
REQ-013 lenLoad  output  8  length load, NR31.
REQ-014 lenEnable  output  1  NR34 bit 6.
REQ-015 freq  output  11  {NR34 bits 2:0, NR33}.
REQ-016 trigger  output  1  one-cycle channel trigger pulse.
REQ-017 samples  output  128  wave table; sample i at bits [4i+3:4i], i = 0..31.

Function
REQ-018 Register map SHALL be: 0x1A NR30, 0x1B NR31, 0x1C NR32, 0x1D NR33, 0x1E NR34, 0x30-0x3F wave RAM; all other addresses are unmapped.
REQ-019 Write to wave byte 0x30+k SHALL set sample 2k = wdata[7:4] and sample 2k+1 = wdata[3:0] on the same clock edge.
REQ-020 Writes to NR30-NR34 SHALL update only the defined bits listed in REQ-011..REQ-015; undefined bits are discarded.
REQ-021 Writes to unmapped addresses SHALL have no effect.
REQ-022 NR34 write with wdata[7]=1 and the new enable value 1 SHALL drive trigger high for exactly the following cycle.
REQ-023 NR34 write with wdata[7]=1 while enable=0 SHALL NOT pulse trigger; lenEnable/freq bits SHALL still update.
REQ-024 Back-to-back NR34 trigger writes SHALL give one pulse per write, i.e. trigger high on consecutive cycles.
REQ-025 Read SHALL return rdata one cycle after rdEn, with rdValid high that cycle only; rdata SHALL hold its value until the next read.
REQ-026 Read masks SHALL be:
- NR30: {enable, 7'h7F}.
- NR31: 0xFF.
- NR32: {1, vol, 5'h1F}.
- NR33: 0xFF.
- NR34: {1, lenEnable, 6'h3F}.
- Wave byte: {sample 2k, sample 2k+1}.
- Unmapped: 0xFF.
REQ-027 If wrEn and rdEn are both high, the write SHALL occur and the read SHALL be ignored: rdValid stays 0 and rdata is unchanged.
REQ-028 While apuOn=0, writes to NR30-NR34 SHALL be ignored and enable, vol, lenLoad, lenEnable, freq, and trigger SHALL be forced to 0 on every cycle.
REQ-029 Wave RAM SHALL be retained and writable regardless of apuOn.
REQ-030 When apuOn falls in the cycle trigger is high, that pulse SHALL still complete; no further pulse SHALL follow.
REQ-031 Register reads while apuOn=0 SHALL reflect the cleared values under the REQ-026 masks.

Reset
REQ-032 On rstN=0 at a clock edge, all outputs SHALL become 0, including all 128 samples bits, rdata=0x00, rdValid=0, and trigger=0.
REQ-033 Reset SHALL override any wrEn or rdEn in the same cycle; a pending trigger pulse or rdValid SHALL be cancelled.

Verification
REQ-034 Write 0x1A=0x80, then 0x1E=0xC5 -> next cycle trigger=1 for one cycle, lenEnable=1, freq[10:8]=3'b101.
REQ-035 Write 0x1A=0x00, then 0x1E=0x80 -> trigger stays 0; read 0x1E -> rdata=0xBF with rdValid=1 for one cycle.
REQ-036 Write 0x30=0xA5, 0x3F=0x3C -> samples[3:0]=0xA, samples[7:4]=0x5, samples[127:124]=0xC; read 0x3F -> 0x3C.
REQ-037 Write 0x1C=0xFF, read 0x1C -> 0xFF with vol=2'b11; read 0x1B and 0x20 -> 0xFF each.
REQ-038 Set registers, drop apuOn, write 0x1C=0x20 -> vol stays 0; read 0x1A -> 0x7F; wave RAM contents unchanged.
REQ-039 Assert rstN=0 together with wrEn to 0x1E=0x80 and rdEn -> next cycle trigger=0, rdValid=0, all outputs 0.
